electronic_clk_gen_phased: RTL and testbench
============================================

# electronic_clk_gen_phased

Multi-channel, runtime-configurable excitation clock generator for the tactile read-wire array. It divides `clk_ref` into N_CH square-wave channel clocks with a programmable half-period and a programmable inter-channel phase step. It supports two modes: all masked channels driven simultaneously, or round-robin scan, where one channel is driven at a time. It sits between the system clock and the electrode drive pins and supersedes the fixed-divider generator.

## Interface
Parameters:
- N_CH, 2, number of read-wire channels (≥1)
- DIV_W, 16, width of divider and phase fields
- DEFAULT_DIV, 1000, half-period in `clk_ref` cycles after reset
- SCAN_PERIODS, 4, full output periods each channel stays active in scan mode (≥1)

Ports:
- clk_ref  in  1  sole clock
- rst  in  1  reset, asynchronous, active-high
- en  in  1  run enable
- mode  in  1  0 = parallel, 1 = scan
- ch_mask  in  N_CH  per-channel drive enable
- cfg_valid  in  1  new configuration offered
- cfg_ready  out  1  configuration can be accepted
- cfg_div  in  DIV_W  half-period H in cycles
- cfg_phase  in  DIV_W  phase step S in cycles between adjacent channels
- clk_out  out  N_CH  channel clocks (registered)
- active_ch  out  max(1,$clog2(N_CH))  channel currently driven in scan mode
- period_tick  out  1  one-cycle pulse at the last cycle of each period

## Operation
- Active config: H (half-period), P = 2H (period), offsets off[k].
- Reset: H = DEFAULT_DIV, S = 0, all off[k] = 0, cnt = 0, state RUN, no pending config. Outputs reset to clk_out = 0, cfg_ready = 1, active_ch = 0, period_tick = 0.
- States:
  - RUN: cnt counts 0..P-1 and wraps while en = 1. cnt is held at 0 while en = 0.
  - LOAD: offsets are being computed.
- Config handshake:
  - Transfer occurs when cfg_valid & cfg_ready at an edge; the values are captured into a pending register.
  - cfg_ready = 0 while a config is pending or state = LOAD.
- Applying a pending config:
  - If en = 1, it is applied at the period boundary (cnt = P-1).
  - If en = 0, it is applied on the next cycle.
  - Applying sets H = max(cfg_div, 1) and sets S = cfg_phase, or S = 0 if cfg_phase ≥ 2H. The block then enters LOAD.
- LOAD:
  - Lasts exactly N_CH cycles. Computes off[0] = 0 and off[k] = off[k-1] + S, subtracting P once if the sum is ≥ P.
  - cnt is held at 0, clk_out = 0 and period_tick = 0 during LOAD.
  - Returns to RUN, and cfg_ready rises on the same edge.
- Channel waveform:
  - d_k = (cnt − off[k]) mod P, computed in DIV_W+1 bits with no overflow.
  - Raw high when d_k < H.
- Parallel mode: clk_out[k] = raw[k] & ch_mask[k] & en & RUN.
- Scan mode:
  - Only clk_out[active_ch] may be high, gated the same way as parallel mode.
  - After SCAN_PERIODS period_ticks, active_ch advances to the next set bit of ch_mask in ascending order, wrapping to the lowest set bit.
  - If ch_mask = 0: all outputs are 0 and active_ch holds.
  - If active_ch's mask bit is cleared, it advances at the next period_tick.
- Mode or mask changes take effect at the next cycle. The scan period count resets to 0 on a mode change.
- Deassertion of en: outputs go to 0 on the next edge and cnt is set to 0. active_ch and the scan count are retained.

## Timing
- clk_out and period_tick are registered, so each lags its cnt value by one cycle.
- With en rising and sampled at edge E0 (so cnt = 0 after E0), the channel with off = 0 is high from edge E1 for exactly H cycles, then low for H cycles.
- period_tick is high for one cycle per P cycles, aligned with the last output cycle of the period.
- Simultaneous events:
  - A cfg transfer on the boundary edge applies at the next boundary, never at the same edge.
  - When a scan advance and a config apply coincide, both take effect: LOAD starts and active_ch advances.
- Reset asserted mid-LOAD or mid-period returns all state to reset values immediately (asynchronous). The pending config is discarded.

## Test plan
- Reset defaults, N_CH=2, DEFAULT_DIV=1000, mask=2'b11, mode 0, en=1 → both clk_out show period 2000 and exact 1000/1000 duty, in phase; period_tick every 2000 cycles.
- Config, N_CH=4, H=4, S=2, mask=4'hF → cfg_ready low for 4 cycles after the boundary; off = 0,2,4,6; channel k rises 2k cycles after channel 0 (channel 3 wraps); period 8.
- Scan, N_CH=4, SCAN_PERIODS=2, mask=4'b1011, H=3 → active_ch sequence 0,1,3,0,…, each for 12 cycles; unselected outputs stay 0; mask=0 → all low, active_ch frozen.
- Mid-period cfg (H=10→H=5) at cnt=7 → the old waveform completes its period, LOAD runs N_CH cycles, then period 10; cfg_ready returns high with RUN.
- Edge values: cfg_div=0 → period 2; cfg_phase=2H → all offsets 0; a second cfg_valid while pending → not accepted (cfg_ready=0).
- Async rst pulse mid-LOAD and mid-scan → outputs 0 within the reset cycle; after release, DEFAULT_DIV behaviour with active_ch=0.

Source files
------------

// File: rtl/electronic_clk_gen_phased.sv
// electronic_clk_gen_phased: phased multi-channel excitation clock
// generator dividing clk_ref, with parallel and round-robin scan modes.
// Ports: clk_ref, rst (async, active-high); en run enable; mode 0=par,
// 1=scan; ch_mask channel enables; cfg_valid/cfg_ready/cfg_div/cfg_phase
// config handshake; clk_out channel clocks; active_ch scanned channel;
// period_tick marks the last output cycle of each period.
module electronic_clk_gen_phased #(
  parameter int N_CH = 2,
  parameter int DIV_W = 16,
  parameter int DEFAULT_DIV = 1000,
  parameter int SCAN_PERIODS = 4,
  localparam int AW = (N_CH > 1) ? $clog2(N_CH) : 1,
  localparam int SW = (SCAN_PERIODS > 1) ? $clog2(SCAN_PERIODS) : 1
) (
  input  logic              clk_ref,
  input  logic              rst,
  input  logic              en,
  input  logic              mode,
  input  logic [N_CH-1:0]   ch_mask,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [DIV_W-1:0]  cfg_phase,
  output logic [N_CH-1:0]   clk_out,
  output logic [AW-1:0]     active_ch,
  output logic              period_tick
);

  typedef enum logic {RUN, LOAD} state_t;

  state_t state, state_nxt;

  logic [DIV_W-1:0] h;
  logic [DIV_W-1:0] s;
  logic [DIV_W:0]   per;
  logic [DIV_W:0]   cnt;
  logic [DIV_W:0]   off [N_CH];
  logic             en_q;
  logic             mode_q;
  logic [SW-1:0]    scan_cnt;
  logic [AW-1:0]    load_idx;

  logic             pend;
  logic [DIV_W-1:0] pend_div;
  logic [DIV_W-1:0] pend_phase;

  logic             run;
  logic             last;
  logic             wrap;
  logic             xfer;
  logic             apply;
  logic             load_last;
  logic [DIV_W-1:0] new_h;
  logic [DIV_W-1:0] new_s;
  logic [DIV_W:0]   load_val;
  logic [N_CH-1:0]  clk_nxt;

  // Smallest set bit above cur, else lowest set bit, else cur.
  function automatic logic [AW-1:0] next_ch(
    input logic [AW-1:0]   cur,
    input logic [N_CH-1:0] m
  );
    logic [AW-1:0] hi;
    logic [AW-1:0] lo;
    logic          fhi;
    logic          flo;
    hi  = cur;
    lo  = cur;
    fhi = 1'b0;
    flo = 1'b0;
    for (int j = N_CH - 1; j >= 0; j--) begin
      if (m[j]) begin
        if (AW'(j) > cur) begin
          hi  = AW'(j);
          fhi = 1'b1;
        end
        lo  = AW'(j);
        flo = 1'b1;
      end
    end
    if (fhi)
      return hi;
    else if (flo)
      return lo;
    return cur;
  endfunction

  assign per = {h, 1'b0};
  // en must have been seen for one edge before counting starts, so
  // cnt = 0 is the first counted cycle; deassertion is immediate.
  assign run = en & en_q & (state == RUN);
  assign last = (cnt == per - 1'b1);
  assign wrap = run & last;
  assign cfg_ready = ~pend & (state == RUN);
  assign xfer = cfg_valid & cfg_ready;
  assign apply = pend & (state == RUN) & (~en | wrap);
  assign load_last = (load_idx == AW'(N_CH - 1));

  assign new_h = (pend_div == '0) ? DIV_W'(1) : pend_div;
  assign new_s =
    ({1'b0, pend_phase} >= {new_h, 1'b0}) ? '0 : pend_phase;

  always_comb begin
    logic [DIV_W:0]   prev;
    logic [DIV_W+1:0] sum;
    prev = '0;
    if (load_idx != '0)
      prev = off[load_idx - 1'b1];
    sum = {1'b0, prev} + (DIV_W+2)'(s);
    load_val = sum[DIV_W:0];
    if (load_idx == '0)
      load_val = '0;
    else if (sum >= {1'b0, per})
      load_val = (DIV_W+1)'(sum - {1'b0, per});
  end

  always_comb begin
    logic [DIV_W:0] d;
    logic           gate;
    clk_nxt = '0;
    d = '0;
    gate = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
      // (cnt - off) mod P without leaving DIV_W+1 bits.
      if (cnt >= off[k])
        d = cnt - off[k];
      else
        d = per - (off[k] - cnt);
      gate = run & ch_mask[k] & (~mode | (active_ch == AW'(k)));
      clk_nxt[k] = gate & (d < {1'b0, h});
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      RUN:  if (apply) state_nxt = LOAD;
      LOAD: if (load_last) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk_ref or posedge rst) begin
    if (rst)
      state <= RUN;
    else
      state <= state_nxt;
  end

  always_ff @(posedge clk_ref or posedge rst) begin
    if (rst) begin
      h <= DIV_W'(DEFAULT_DIV);
      s <= '0;
      cnt <= '0;
      for (int k = 0; k < N_CH; k++)
        off[k] <= '0;
      en_q <= 1'b0;
      mode_q <= 1'b0;
      scan_cnt <= '0;
      load_idx <= '0;
      pend <= 1'b0;
      pend_div <= '0;
      pend_phase <= '0;
      active_ch <= '0;
      clk_out <= '0;
      period_tick <= 1'b0;
    end else begin
      en_q <= en;
      mode_q <= mode;
      clk_out <= clk_nxt;
      period_tick <= wrap;
      cnt <= (run & ~last) ? cnt + 1'b1 : '0;

      if (xfer) begin
        pend <= 1'b1;
        pend_div <= cfg_div;
        pend_phase <= cfg_phase;
      end else if (apply) begin
        pend <= 1'b0;
      end

      if (apply) begin
        h <= new_h;
        s <= new_s;
        load_idx <= '0;
      end else if (state == LOAD) begin
        off[load_idx] <= load_val;
        load_idx <= load_idx + 1'b1;
      end

      if (mode != mode_q) begin
        scan_cnt <= '0;
      end else if (wrap & mode & (|ch_mask)) begin
        // A deselected current channel is left at the next tick.
        if (!ch_mask[active_ch] ||
            scan_cnt == SW'(SCAN_PERIODS - 1)) begin
          active_ch <= next_ch(active_ch, ch_mask);
          scan_cnt <= '0;
        end else begin
          scan_cnt <= scan_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_electronic_clk_gen_phased.sv
// tb_electronic_clk_gen_phased: table vectors and scoreboard bench
// for the phased excitation clock generator (N_CH=4, SCAN_PERIODS=2).
module tb_electronic_clk_gen_phased;

  logic        clk_ref = 1'b0;
  logic        rst;
  logic        en;
  logic        mode;
  logic [3:0]  ch_mask;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [15:0] cfg_div;
  logic [15:0] cfg_phase;
  logic [3:0]  clk_out;
  logic [1:0]  active_ch;
  logic        period_tick;

  electronic_clk_gen_phased #(
    .N_CH(4),
    .DIV_W(16),
    .DEFAULT_DIV(1000),
    .SCAN_PERIODS(2)
  ) dut (
    .clk_ref(clk_ref),
    .rst(rst),
    .en(en),
    .mode(mode),
    .ch_mask(ch_mask),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_div(cfg_div),
    .cfg_phase(cfg_phase),
    .clk_out(clk_out),
    .active_ch(active_ch),
    .period_tick(period_tick)
  );

  always #5 clk_ref = ~clk_ref;

  // Observed byte: {cfg_ready, active_ch, period_tick, clk_out}
  typedef struct {
    int         edge_no;
    logic [7:0] care;
    logic [7:0] val;
    string      nm;
  } exp_t;

  typedef struct {
    logic [15:0]     div;
    logic [15:0]     phase;
    logic [3:0]      mask;
    int              h;
    logic [3:0][7:0] off;
  } vec_t;

  exp_t sb_q[$];
  vec_t vt[6];
  int checks = 0;
  int errors = 0;
  int edge_n = 0;

  always @(posedge clk_ref) edge_n <= edge_n + 1;

  task automatic check(string nm, logic [7:0] care, logic [7:0] want);
    logic [7:0] act;
    act = {cfg_ready, active_ch, period_tick, clk_out};
    checks++;
    if ((act & care) !== (want & care)) begin
      errors++;
      $display("FAIL %s edge %0d: got %b want %b care %b",
               nm, edge_n, act, want, care);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk_ref);
      while (sb_q.size() > 0 && sb_q[0].edge_no <= edge_n) begin
        e = sb_q.pop_front();
        check(e.nm, e.care, e.val);
      end
    end
  end

  task automatic step(string nm, logic [7:0] care, logic [7:0] val);
    exp_t e;
    e.edge_no = edge_n + 1;
    e.care = care;
    e.val = val;
    e.nm = nm;
    sb_q.push_back(e);
    @(posedge clk_ref);
    #1;
  endtask

  function automatic bit wave(int n, int h, int off);
    int p;
    int d;
    p = 2 * h;
    d = ((n - off) % p + p) % p;
    return d < h;
  endfunction

  task automatic load_cfg(logic [15:0] d, logic [15:0] p);
    en = 1'b0;
    check("ready_idle", 8'h80, 8'h80);
    cfg_div = d;
    cfg_phase = p;
    cfg_valid = 1'b1;
    step("xfer", 8'h9F, 8'h00);
    cfg_valid = 1'b0;
    for (int i = 0; i < 4; i++)
      step("load_busy", 8'h9F, 8'h00);
    step("load_done", 8'h9F, 8'h80);
  endtask

  task automatic run_par(string nm, int h, logic [3:0][7:0] off,
                         logic [3:0] mask, int edges);
    logic [3:0] c;
    logic       tk;
    int         n;
    ch_mask = mask;
    mode = 1'b0;
    en = 1'b1;
    step({nm, "_start"}, 8'h9F, 8'h80);
    for (int m = 1; m <= edges; m++) begin
      n = m - 1;
      for (int k = 0; k < 4; k++)
        c[k] = mask[k] & wave(n, h, int'(off[k]));
      tk = ((n % (2 * h)) == 2 * h - 1);
      step(nm, 8'hFF, {1'b1, 2'b00, tk, c});
    end
    en = 1'b0;
    step({nm, "_stop"}, 8'h9F, 8'h80);
  endtask

  initial begin
    int         seq [3];
    logic [3:0] c;
    logic       tk;
    logic       rdy;
    logic [1:0] ach;
    int         n;

    seq = '{0, 1, 3};
    vt[0] = '{16'd4, 16'd2, 4'hF, 4, {8'd6, 8'd4, 8'd2, 8'd0}};
    vt[1] = '{16'd0, 16'd0, 4'hF, 1, {8'd0, 8'd0, 8'd0, 8'd0}};
    vt[2] = '{16'd3, 16'd6, 4'hF, 3, {8'd0, 8'd0, 8'd0, 8'd0}};
    vt[3] = '{16'd5, 16'd3, 4'h5, 5, {8'd9, 8'd6, 8'd3, 8'd0}};
    vt[4] = '{16'd3, 16'd4, 4'hF, 3, {8'd0, 8'd2, 8'd4, 8'd0}};
    vt[5] = '{16'd0, 16'd1, 4'hF, 1, {8'd1, 8'd0, 8'd1, 8'd0}};

    rst = 1'b1;
    en = 1'b0;
    mode = 1'b0;
    ch_mask = 4'h0;
    cfg_valid = 1'b0;
    cfg_div = '0;
    cfg_phase = '0;
    repeat (2) @(posedge clk_ref);
    #1;
    check("reset", 8'hFF, 8'h80);
    rst = 1'b0;
    step("idle", 8'hFF, 8'h80);
    step("idle", 8'hFF, 8'h80);

    run_par("dflt", 1000, '0, 4'b0011, 4001);

    for (int i = 0; i < 6; i++) begin
      load_cfg(vt[i].div, vt[i].phase);
      run_par($sformatf("vec%0d", i), vt[i].h, vt[i].off,
              vt[i].mask, 4 * vt[i].h + 1);
    end

    load_cfg(16'd3, 16'd0);
    mode = 1'b1;
    ch_mask = 4'b1011;
    en = 1'b1;
    for (int m = 0; m <= 84; m++) begin
      ach = 2'(seq[(m / 12) % 3]);
      c = 4'h0;
      tk = 1'b0;
      if (m > 0) begin
        n = m - 1;
        if (wave(n, 3, 0))
          c = 4'(1 << seq[(n / 12) % 3]);
        tk = ((n % 6) == 5);
      end
      step("scan", 8'h7F, {1'b0, ach, tk, c});
    end
    ch_mask = 4'h0;
    for (int m = 0; m < 30; m++)
      step("scan_mask0", 8'h6F, {1'b0, 2'd1, 1'b0, 4'h0});
    ch_mask = 4'b1011;
    repeat (4) @(posedge clk_ref);
    @(negedge clk_ref);
    #2;
    rst = 1'b1;
    #1;
    check("rst_scan", 8'hFF, 8'h80);
    mode = 1'b0;
    en = 1'b0;
    ch_mask = 4'h0;
    @(posedge clk_ref);
    #1;
    rst = 1'b0;

    cfg_div = 16'd7;
    cfg_phase = 16'd0;
    cfg_valid = 1'b1;
    step("mid_xfer", 8'h9F, 8'h00);
    cfg_valid = 1'b0;
    step("mid_load", 8'h9F, 8'h00);
    step("mid_load", 8'h9F, 8'h00);
    @(negedge clk_ref);
    #2;
    rst = 1'b1;
    #1;
    check("rst_load", 8'hFF, 8'h80);
    @(posedge clk_ref);
    #1;
    rst = 1'b0;
    run_par("post_rst", 1000, '0, 4'b0001, 1002);

    load_cfg(16'd10, 16'd0);
    mode = 1'b0;
    ch_mask = 4'b0001;
    en = 1'b1;
    for (int m = 0; m <= 60; m++) begin
      cfg_valid = (m == 8) || (m == 12);
      cfg_div = (m == 8) ? 16'd5 : 16'd1;
      c = 4'h0;
      tk = 1'b0;
      if (m >= 1 && m <= 20) begin
        c[0] = wave(m - 1, 10, 0);
        tk = ((m - 1) % 20) == 19;
      end else if (m >= 25) begin
        c[0] = wave(m - 25, 5, 0);
        tk = ((m - 25) % 10) == 9;
      end
      rdy = (m < 8) || (m >= 24);
      step("mid_cfg", 8'hFF, {rdy, 2'b00, tk, c});
    end
    cfg_valid = 1'b0;
    en = 1'b0;

    repeat (3) @(posedge clk_ref);
    @(negedge clk_ref);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left want 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, checks %0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
